// File: rtl/nrisc_ula_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nrisc_ula_pkg                                                   |
// | Purpose  : Opcodes, flag indices and engine states for the sequential ULA.  |
// |            NRISC_ULA_DIV_EN adds the divide opcodes to the iterative set.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package nrisc_ula_pkg;

    localparam int TAM_DEF = 32;

    localparam logic [3:0] ULA_ADD   = 4'd0;
    localparam logic [3:0] ULA_SUB   = 4'd1;
    localparam logic [3:0] ULA_AND   = 4'd2;
    localparam logic [3:0] ULA_NAND  = 4'd3;
    localparam logic [3:0] ULA_OR    = 4'd4;
    localparam logic [3:0] ULA_XOR   = 4'd5;
    localparam logic [3:0] ULA_SHR   = 4'd6;
    localparam logic [3:0] ULA_SAR   = 4'd7;
    localparam logic [3:0] ULA_SHL   = 4'd8;
    localparam logic [3:0] ULA_ROL   = 4'd9;
    localparam logic [3:0] ULA_ROR   = 4'd10;
    localparam logic [3:0] ULA_MUL   = 4'd11;
    localparam logic [3:0] ULA_MULHU = 4'd12;
    localparam logic [3:0] ULA_DIVU  = 4'd13;
    localparam logic [3:0] ULA_REMU  = 4'd14;

    localparam int FLG_MINUS = 2;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_CARRY = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } ula_state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef NRISC_ULA_DIV_EN
        return (op == ULA_MUL) || (op == ULA_MULHU) || (op == ULA_DIVU) || (op == ULA_REMU);
`else
        return (op == ULA_MUL) || (op == ULA_MULHU);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/nrisc_ula_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nrisc_ula_iter                                                  |
// | Purpose  : Bit-serial unsigned multiplier and (NRISC_ULA_DIV_EN) restoring  |
// |            divider; done/result are presented on the final iteration.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module nrisc_ula_iter
    import nrisc_ula_pkg::*;
#(
    parameter int TAM = TAM_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [3:0]     op,
    input  logic [TAM-1:0] a,
    input  logic [TAM-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [TAM-1:0] result,
    output logic           carry
);
    localparam int SHW = $clog2(TAM);

    ula_state_t       state, state_nx;
    logic [SHW-1:0]   cnt;
    logic [3:0]       op_r;
    logic [TAM-1:0]   mcand;
    logic [2*TAM-1:0] acc, acc_nx;
    logic [TAM:0]     mul_sum;
    logic             last;
`ifdef NRISC_ULA_DIV_EN
    logic [TAM-1:0]   rem, rem_nx, quo, quo_nx, dvsr;
    logic [TAM:0]     rem_sh, rem_diff;
`endif

    assign last = (cnt == SHW'(TAM - 1));
    assign busy = (state == ST_MUL) || (state == ST_DIV);
    assign done = busy && last;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef NRISC_ULA_DIV_EN
                    state_nx = ((op == ULA_DIVU) || (op == ULA_REMU)) ? ST_DIV : ST_MUL;
`else
                    state_nx = ST_MUL;
`endif
                end
            end
            ST_MUL: if (last) state_nx = ST_IDLE;
`ifdef NRISC_ULA_DIV_EN
            ST_DIV: if (last) state_nx = ST_IDLE;
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next-iteration values feed both the work registers and the result port,
    // so the top can capture the answer on the very edge that finishes it.
    always_comb begin
        mul_sum = {1'b0, acc[2*TAM-1:TAM]} + (acc[0] ? {1'b0, mcand} : {(TAM+1){1'b0}});
        acc_nx  = {mul_sum, acc[TAM-1:1]};
        result  = acc_nx[TAM-1:0];
        carry   = |acc_nx[2*TAM-1:TAM];
        if (op_r == ULA_MULHU)
            result = acc_nx[2*TAM-1:TAM];
`ifdef NRISC_ULA_DIV_EN
        rem_sh   = {rem, quo[TAM-1]};
        rem_diff = rem_sh - {1'b0, dvsr};
        quo_nx   = {quo[TAM-2:0], ~rem_diff[TAM]};
        rem_nx   = rem_diff[TAM] ? rem_sh[TAM-1:0] : rem_diff[TAM-1:0];
        if (op_r == ULA_DIVU) begin
            result = quo_nx;
            carry  = ~|dvsr;
        end else if (op_r == ULA_REMU) begin
            result = rem_nx;
            carry  = ~|dvsr;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            op_r  <= '0;
            mcand <= '0;
            acc   <= '0;
`ifdef NRISC_ULA_DIV_EN
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
`endif
        end else if ((state == ST_IDLE) && start) begin
            cnt   <= '0;
            op_r  <= op;
            mcand <= a;
            acc   <= {{TAM{1'b0}}, b};
`ifdef NRISC_ULA_DIV_EN
            rem   <= '0;
            quo   <= a;
            dvsr  <= b;
`endif
        end else if (busy) begin
            cnt <= cnt + SHW'(1);
            if (state == ST_MUL)
                acc <= acc_nx;
`ifdef NRISC_ULA_DIV_EN
            if (state == ST_DIV) begin
                rem <= rem_nx;
                quo <= quo_nx;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/nrisc_ula_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nrisc_ula_seq                                                   |
// | Purpose  : Multi-cycle NRISC ULA with start/done handshake. Divider only    |
// |            present when NRISC_ULA_DIV_EN is defined.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module nrisc_ula_seq
    import nrisc_ula_pkg::*;
#(
    parameter int TAM = TAM_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ULA_start,
    input  logic [3:0]     ULA_ctrl,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    output logic           ULA_busy,
    output logic           ULA_done,
    output logic [TAM-1:0] ULA_OUT,
    output logic [2:0]     ULA_flags
);
    localparam int SHW = $clog2(TAM);

    logic           iter_op, eng_done, eng_carry;
    logic [TAM-1:0] eng_res;
    logic [SHW-1:0] amt, amt_m1, inv;
    logic           amt_nz;
    logic [TAM:0]   sum, dif;
    logic [TAM-1:0] res;
    logic           c, ovf, rsvd;
    logic [2:0]     flags_s;

    assign iter_op = is_iter_op(ULA_ctrl);

    nrisc_ula_iter #(.TAM(TAM)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (ULA_start && iter_op),
        .op     (ULA_ctrl),
        .a      (ULA_A),
        .b      (ULA_B),
        .busy   (ULA_busy),
        .done   (eng_done),
        .result (eng_res),
        .carry  (eng_carry)
    );

    assign amt    = ULA_B[SHW-1:0];
    assign amt_nz = |amt;
    assign amt_m1 = amt - SHW'(1);
    assign inv    = {SHW{1'b0}} - amt;   // (TAM - amt) mod TAM
    assign sum    = {1'b0, ULA_A} + {1'b0, ULA_B};
    assign dif    = {1'b0, ULA_A} - {1'b0, ULA_B};

    always_comb begin
        res  = '0;
        c    = 1'b0;
        ovf  = 1'b0;
        rsvd = 1'b0;
        case (ULA_ctrl)
            ULA_ADD: begin
                res = sum[TAM-1:0];
                c   = sum[TAM];
                ovf = (ULA_A[TAM-1] == ULA_B[TAM-1]) && (sum[TAM-1] != ULA_A[TAM-1]);
            end
            ULA_SUB: begin
                res = dif[TAM-1:0];
                c   = dif[TAM];
                ovf = (ULA_A[TAM-1] != ULA_B[TAM-1]) && (dif[TAM-1] != ULA_A[TAM-1]);
            end
            ULA_AND:  res = ULA_A & ULA_B;
            ULA_NAND: res = ~(ULA_A & ULA_B);
            ULA_OR:   res = ULA_A | ULA_B;
            ULA_XOR:  res = ULA_A ^ ULA_B;
            ULA_SHR: begin
                res = ULA_A >> amt;
                c   = amt_nz & ULA_A[amt_m1];
            end
            ULA_SAR: begin
                res = TAM'($signed(ULA_A) >>> amt);
                c   = amt_nz & ULA_A[amt_m1];
            end
            ULA_SHL: begin
                res = ULA_A << amt;
                c   = amt_nz & ULA_A[inv];
            end
            ULA_ROL: begin
                res = (ULA_A << amt) | (ULA_A >> inv);
                c   = amt_nz & res[0];
            end
            ULA_ROR: begin
                res = (ULA_A >> amt) | (ULA_A << inv);
                c   = amt_nz & res[TAM-1];
            end
            default: rsvd = 1'b1;
        endcase
        flags_s            = '0;
        flags_s[FLG_MINUS] = res[TAM-1] ^ ovf;
        flags_s[FLG_ZERO]  = (res == '0) && !rsvd;
        flags_s[FLG_CARRY] = c;
    end

    // Engine completion wins; single-cycle starts are only taken when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ULA_OUT   <= '0;
            ULA_flags <= '0;
            ULA_done  <= 1'b0;
        end else begin
            ULA_done <= 1'b0;
            if (eng_done) begin
                ULA_OUT              <= eng_res;
                ULA_flags[FLG_MINUS] <= eng_res[TAM-1];
                ULA_flags[FLG_ZERO]  <= (eng_res == '0);
                ULA_flags[FLG_CARRY] <= eng_carry;
                ULA_done             <= 1'b1;
            end else if (ULA_start && !ULA_busy && !iter_op) begin
                ULA_OUT   <= res;
                ULA_flags <= flags_s;
                ULA_done  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nrisc_ula_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_nrisc_ula_seq                                                |
// | Purpose  : Directed self-checking bench for nrisc_ula_seq (TAM=32).         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_nrisc_ula_seq;
    import nrisc_ula_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ULA_start;
    logic [3:0]  ULA_ctrl;
    logic [31:0] ULA_A, ULA_B;
    logic        ULA_busy, ULA_done;
    logic [31:0] ULA_OUT;
    logic [2:0]  ULA_flags;

    int n_cmp = 0;
    int n_bad = 0;
    int lat, bcnt;
    logic saw;

    nrisc_ula_seq #(.TAM(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ULA_start (ULA_start),
        .ULA_ctrl  (ULA_ctrl),
        .ULA_A     (ULA_A),
        .ULA_B     (ULA_B),
        .ULA_busy  (ULA_busy),
        .ULA_done  (ULA_done),
        .ULA_OUT   (ULA_OUT),
        .ULA_flags (ULA_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one op and wait (bounded) for done; lat=1 means done right after
    // the edge that sampled start. Optionally fires a stray start while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit stray, output int l, output int bc);
        @(negedge clk);
        ULA_ctrl = op; ULA_A = a; ULA_B = b; ULA_start = 1'b1;
        @(posedge clk); #1;
        ULA_start = 1'b0;
        l = 1; bc = 0;
        while (!ULA_done && l < 100) begin
            if (ULA_busy) bc++;
            if (stray && l == 5) begin
                ULA_start = 1'b1; ULA_ctrl = ULA_ADD; ULA_A = 32'd1; ULA_B = 32'd1;
            end else begin
                ULA_start = 1'b0;
            end
            @(posedge clk); #1;
            l++;
        end
        ULA_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ULA_start = 1'b0; ULA_ctrl = '0; ULA_A = '0; ULA_B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out",   ULA_OUT, 32'h0);
        chk("rst_flags", 32'(ULA_flags), 32'h0);
        chk("rst_done",  32'(ULA_done), 32'h0);
        chk("rst_busy",  32'(ULA_busy), 32'h0);
        rst_n = 1'b1;

        run_op(ULA_ADD, 32'hFFFF_FFFF, 32'h1, 0, lat, bcnt);
        chk("add_out", ULA_OUT, 32'h0);
        chk("add_flags", 32'(ULA_flags), 32'b011);
        chk("add_lat", lat, 1);
        chk("add_busy", bcnt, 0);

        run_op(ULA_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt);
        chk("sub_out", ULA_OUT, 32'h8000_0000);
        chk("sub_flags", 32'(ULA_flags), 32'b001);
        chk("sub_lat", lat, 1);
        @(posedge clk); #1;
        chk("done_pulse", 32'(ULA_done), 32'h0);
        chk("out_hold", ULA_OUT, 32'h8000_0000);

        // Abort a multiply at iteration 10.
        @(negedge clk);
        ULA_ctrl = ULA_MUL; ULA_A = 32'd3; ULA_B = 32'd5; ULA_start = 1'b1;
        @(posedge clk); #1;
        ULA_start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out",   ULA_OUT, 32'h0);
        chk("abort_flags", 32'(ULA_flags), 32'h0);
        chk("abort_busy",  32'(ULA_busy), 32'h0);
        chk("abort_done",  32'(ULA_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ULA_done) saw = 1'b1;
        end
        chk("abort_no_done", 32'(saw), 32'h0);

        run_op(ULA_ADD, 32'd2, 32'd3, 0, lat, bcnt);
        chk("add2_out", ULA_OUT, 32'd5);
        chk("add2_flags", 32'(ULA_flags), 32'b000);

        // Back-to-back single-cycle ops.
        @(negedge clk);
        ULA_ctrl = ULA_AND; ULA_A = 32'hF0F0_00FF; ULA_B = 32'h0FF0_0F0F; ULA_start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_and_out", ULA_OUT, 32'h00F0_000F);
        chk("b2b_and_done", 32'(ULA_done), 32'h1);
        @(negedge clk);
        ULA_ctrl = ULA_XOR;
        @(posedge clk); #1;
        ULA_start = 1'b0;
        chk("b2b_xor_out", ULA_OUT, 32'hFF00_0FF0);
        chk("b2b_xor_flags", 32'(ULA_flags), 32'b100);
        chk("b2b_xor_done", 32'(ULA_done), 32'h1);

        run_op(ULA_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt);
        chk("nand_out", ULA_OUT, 32'h0);
        chk("nand_flags", 32'(ULA_flags), 32'b010);

        run_op(ULA_ROL, 32'h8000_0001, 32'd1, 0, lat, bcnt);
        chk("rol_out", ULA_OUT, 32'h0000_0003);
        chk("rol_flags", 32'(ULA_flags), 32'b001);

        run_op(ULA_ROR, 32'h0000_0001, 32'd1, 0, lat, bcnt);
        chk("ror_out", ULA_OUT, 32'h8000_0000);
        chk("ror_flags", 32'(ULA_flags), 32'b101);

        run_op(ULA_SAR, 32'h8000_0000, 32'd31, 0, lat, bcnt);
        chk("sar_out", ULA_OUT, 32'hFFFF_FFFF);
        chk("sar_flags", 32'(ULA_flags), 32'b100);

        run_op(ULA_SHR, 32'h0000_0003, 32'd1, 0, lat, bcnt);
        chk("shr_out", ULA_OUT, 32'h0000_0001);
        chk("shr_flags", 32'(ULA_flags), 32'b001);

        run_op(ULA_SHL, 32'h1234_5678, 32'd0, 0, lat, bcnt);
        chk("shl0_out", ULA_OUT, 32'h1234_5678);
        chk("shl0_flags", 32'(ULA_flags), 32'b000);

        run_op(ULA_SHL, 32'h8000_0001, 32'd33, 0, lat, bcnt);
        chk("shl33_out", ULA_OUT, 32'h0000_0002);
        chk("shl33_flags", 32'(ULA_flags), 32'b001);

        run_op(4'd15, 32'd5, 32'd5, 0, lat, bcnt);
        chk("rsvd_out", ULA_OUT, 32'h0);
        chk("rsvd_flags", 32'(ULA_flags), 32'b000);

        run_op(ULA_MUL, 32'h0001_0000, 32'h0001_0000, 0, lat, bcnt);
        chk("mul_out", ULA_OUT, 32'h0);
        chk("mul_flags", 32'(ULA_flags), 32'b011);
        chk("mul_lat", lat, 33);
        chk("mul_busy", bcnt, 32);

        run_op(ULA_MULHU, 32'h0001_0000, 32'h0001_0000, 1, lat, bcnt);
        chk("mulhu_out", ULA_OUT, 32'h1);
        chk("mulhu_flags", 32'(ULA_flags), 32'b001);
        chk("mulhu_lat", lat, 33);

        run_op(ULA_MUL, 32'd12345, 32'd6789, 0, lat, bcnt);
        chk("mul2_out", ULA_OUT, 32'd83810205);

`ifdef NRISC_ULA_DIV_EN
        run_op(ULA_DIVU, 32'd100, 32'd7, 0, lat, bcnt);
        chk("divu_out", ULA_OUT, 32'd14);
        chk("divu_flags", 32'(ULA_flags), 32'b000);
        chk("divu_lat", lat, 33);
        run_op(ULA_REMU, 32'd100, 32'd7, 0, lat, bcnt);
        chk("remu_out", ULA_OUT, 32'd2);
        run_op(ULA_DIVU, 32'd5, 32'd0, 0, lat, bcnt);
        chk("div0_out", ULA_OUT, 32'hFFFF_FFFF);
        chk("div0_flags", 32'(ULA_flags), 32'b101);
        chk("div0_lat", lat, 33);
        run_op(ULA_REMU, 32'd5, 32'd0, 0, lat, bcnt);
        chk("rem0_out", ULA_OUT, 32'd5);
`else
        run_op(ULA_DIVU, 32'd100, 32'd7, 0, lat, bcnt);
        chk("divu_off_out", ULA_OUT, 32'h0);
        chk("divu_off_flags", 32'(ULA_flags), 32'b000);
        chk("divu_off_lat", lat, 1);
        chk("divu_off_busy", bcnt, 0);
        run_op(ULA_REMU, 32'd100, 32'd7, 0, lat, bcnt);
        chk("remu_off_out", ULA_OUT, 32'h0);
        chk("remu_off_lat", lat, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
